// File: rtl/tiled_pkg.sv
// Shared types and elaboration-time helpers for the tiled address generator.
// State encoding, the minimum-1 width rule and the derived tile/drain constants live here.
package tiled_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bits needed to hold values 0..range-1, never less than one bit.
  function automatic int clog2_min1(input int range);
    return (range <= 2) ? 1 : $clog2(range);
  endfunction

  // Cycles needed for the last operand to ripple through an n1 x n2 grid.
  function automatic int drain_cycles(input int n1, input int n2);
    return n1 + n2 - 1;
  endfunction

  // Number of tiles of height/width `tile` along a dimension of size `dim`.
  function automatic int tile_count(input int dim, input int tile);
    return dim / tile;
  endfunction

  // Constants for the default 8x8x8 multiply on a 4x4 grid.
  localparam int DEF_N1    = 4;
  localparam int DEF_N2    = 4;
  localparam int DEF_MR    = 8;
  localparam int DEF_KD    = 8;
  localparam int DEF_PC    = 8;
  localparam int DRAIN_CYC = drain_cycles(DEF_N1, DEF_N2);
  localparam int TILES_A   = tile_count(DEF_MR, DEF_N1);
  localparam int TILES_B   = tile_count(DEF_PC, DEF_N2);

endpackage

// File: rtl/nested_tile_cntr.sv
// Three cascaded wrap counters: k (inner beat) -> tile column -> tile row.
// The whole cascade advances only when en_i is high; clr_i forces all to zero.
module nested_tile_cntr
  import tiled_pkg::*;
#(
  parameter int KD = 8,
  parameter int TA = 2,
  parameter int TB = 2,
  localparam int KW  = clog2_min1(KD),
  localparam int TRW = clog2_min1(TA),
  localparam int TCW = clog2_min1(TB)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [KW-1:0]  k_o,
  output logic [TCW-1:0] col_o,
  output logic [TRW-1:0] row_o,
  output logic           k_wrap_o,
  output logic           last_o
);

  logic [KW-1:0]  k_q, k_d;
  logic [TCW-1:0] col_q, col_d;
  logic [TRW-1:0] row_q, row_d;
  logic           k_wrap, col_wrap, row_wrap;

  assign k_wrap   = (k_q == KW'(KD - 1));
  assign col_wrap = (col_q == TCW'(TB - 1));
  assign row_wrap = (row_q == TRW'(TA - 1));

  // Next-count logic: each stage steps only when every faster stage wraps.
  always_comb begin
    k_d   = k_q;
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      k_d   = '0;
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (k_wrap) begin
        k_d = '0;
        if (col_wrap) begin
          col_d = '0;
          row_d = row_wrap ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  // Counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q   <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      k_q   <= k_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign k_o      = k_q;
  assign col_o    = col_q;
  assign row_o    = row_q;
  assign k_wrap_o = k_wrap;
  assign last_o   = k_wrap & col_wrap & row_wrap;

endmodule

// File: rtl/tiled_addr_gen.sv
// Operand-buffer read address generator for a rectangular tiled multiply
// C[MR x PC] = A[MR x KD] * B[KD x PC] on an N1 x N2 PE grid.
// Optional feature: define TILED_ADDR_BASE_EN to add per-operation base
// addresses (base_addr_A / base_addr_B) captured when start is accepted.
//
// Handshake: start is sampled only in IDLE. rd_en marks a valid address beat;
// stall is downstream back-pressure and, in RUN, suppresses the beat and holds
// every counter for that cycle. done pulses for one cycle after the drain.
module tiled_addr_gen
  import tiled_pkg::*;
#(
  parameter int N1 = 4,
  parameter int N2 = 4,
  parameter int MR = 8,
  parameter int KD = 8,
  parameter int PC = 8,
  localparam int T_A   = tile_count(MR, N1),
  localparam int T_B   = tile_count(PC, N2),
  localparam int D_CYC = drain_cycles(N1, N2),
  localparam int KW    = clog2_min1(KD),
  localparam int TRW   = clog2_min1(T_A),
  localparam int TCW   = clog2_min1(T_B),
  localparam int AW_A  = clog2_min1(T_A * KD),
  localparam int AW_B  = clog2_min1(T_B * KD),
  localparam int DW    = clog2_min1(D_CYC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall,
`ifdef TILED_ADDR_BASE_EN
  input  logic [AW_A-1:0] base_addr_A,
  input  logic [AW_B-1:0] base_addr_B,
`endif
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [AW_A-1:0] rd_addr_A,
  output logic [AW_B-1:0] rd_addr_B,
  output logic [KW-1:0]   k_cntr,
  output logic [TRW-1:0]  tile_row,
  output logic [TCW-1:0]  tile_col,
  output logic            acc_clr,
  output logic            acc_last,
  output state_e          dbg_state
);

  state_e          state_q;
  logic [DW-1:0]   drain_q;
  logic            accept;
  logic            beat_en;
  logic            k_wrap;
  logic            last_beat;
  logic [AW_A-1:0] addr_a_raw;
  logic [AW_B-1:0] addr_b_raw;

  assign accept  = (state_q == IDLE) & start;
  assign beat_en = (state_q == RUN) & ~stall;

  nested_tile_cntr #(
    .KD (KD),
    .TA (T_A),
    .TB (T_B)
  ) u_cntr (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept),
    .en_i     (beat_en),
    .k_o      (k_cntr),
    .col_o    (tile_col),
    .row_o    (tile_row),
    .k_wrap_o (k_wrap),
    .last_o   (last_beat)
  );

  // Operation FSM: IDLE -> RUN (address beats) -> DRAIN (grid flush) -> DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_q <= RUN;
        end
        RUN: begin
          if (beat_en && last_beat) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end
        end
        DRAIN: begin
          // Fixed length; back-pressure does not stretch the flush.
          if (drain_q == DW'(D_CYC - 1)) state_q <= DONE;
          else                           drain_q <= drain_q + 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr_a_raw = AW_A'(tile_row) * AW_A'(KD) + AW_A'(k_cntr);
  assign addr_b_raw = AW_B'(tile_col) * AW_B'(KD) + AW_B'(k_cntr);

`ifdef TILED_ADDR_BASE_EN
  logic [AW_A-1:0] base_a_q;
  logic [AW_B-1:0] base_b_q;

  // Latch the operand-set base addresses when an operation is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_a_q <= '0;
      base_b_q <= '0;
    end else if (accept) begin
      base_a_q <= base_addr_A;
      base_b_q <= base_addr_B;
    end
  end

  assign rd_addr_A = addr_a_raw + base_a_q;
  assign rd_addr_B = addr_b_raw + base_b_q;
`else
  assign rd_addr_A = addr_a_raw;
  assign rd_addr_B = addr_b_raw;
`endif

  assign rd_en     = beat_en;
  assign busy      = (state_q == RUN) | (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign acc_clr   = beat_en & (k_cntr == '0);
  assign acc_last  = beat_en & k_wrap;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tiled_addr_gen.sv
// Bench for tiled_addr_gen: default 8x8x8 instance plus a 12x5x8 instance.
module tb_tiled_addr_gen;
  import tiled_pkg::*;

  localparam int DRAIN = 7;
`ifdef TILED_ADDR_BASE_EN
  localparam int BA2 = 3;
  localparam int BB2 = 2;
`else
  localparam int BA2 = 0;
  localparam int BB2 = 0;
`endif

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic       clr;
    logic       last;
    logic [2:0] k;
    logic [1:0] tr;
    logic       tc;
    logic [3:0] a;
    logic [3:0] b;
  } out_t;

  typedef struct {
    logic start;
    logic stall;
    out_t exp;
  } vec_t;

  vec_t vec_q[$];
  int   checks = 0;
  int   errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 1: defaults ----------------
  logic       start1 = 1'b0, stall1 = 1'b0;
  logic       d1_busy, d1_done, d1_rd_en, d1_clr, d1_last;
  logic [3:0] d1_a, d1_b;
  logic [2:0] d1_k;
  logic       d1_tr, d1_tc;
  state_e     d1_state;

  // ---------------- DUT 2: MR=12, KD=5 ----------------
  logic       start2 = 1'b0, stall2 = 1'b0;
  logic       d2_busy, d2_done, d2_rd_en, d2_clr, d2_last;
  logic [3:0] d2_a, d2_b;
  logic [2:0] d2_k;
  logic [1:0] d2_tr;
  logic       d2_tc;
  state_e     d2_state;

`ifdef TILED_ADDR_BASE_EN
  logic [3:0] base1_a = 4'd0, base1_b = 4'd0;
  logic [3:0] base2_a = 4'(BA2), base2_b = 4'(BB2);
`endif

  tiled_addr_gen u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .stall(stall1),
`ifdef TILED_ADDR_BASE_EN
    .base_addr_A(base1_a), .base_addr_B(base1_b),
`endif
    .busy(d1_busy), .done(d1_done), .rd_en(d1_rd_en),
    .rd_addr_A(d1_a), .rd_addr_B(d1_b), .k_cntr(d1_k),
    .tile_row(d1_tr), .tile_col(d1_tc),
    .acc_clr(d1_clr), .acc_last(d1_last), .dbg_state(d1_state)
  );

  tiled_addr_gen #(.N1(4), .N2(4), .MR(12), .KD(5), .PC(8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .stall(stall2),
`ifdef TILED_ADDR_BASE_EN
    .base_addr_A(base2_a), .base_addr_B(base2_b),
`endif
    .busy(d2_busy), .done(d2_done), .rd_en(d2_rd_en),
    .rd_addr_A(d2_a), .rd_addr_B(d2_b), .k_cntr(d2_k),
    .tile_row(d2_tr), .tile_col(d2_tc),
    .acc_clr(d2_clr), .acc_last(d2_last), .dbg_state(d2_state)
  );

  // ---------------- helpers ----------------
  function automatic out_t mk_out(input logic busy, input logic done, input logic rd_en,
                                  input logic clr, input logic last, input int k,
                                  input int tr, input int tc, input int a, input int b);
    out_t o;
    o.busy = busy; o.done = done; o.rd_en = rd_en; o.clr = clr; o.last = last;
    o.k = 3'(k); o.tr = 2'(tr); o.tc = 1'(tc);
    o.a = 4'(a % 16); o.b = 4'(b % 16);
    return o;
  endfunction

  function automatic out_t get_out(input int sel);
    out_t o;
    if (sel == 1) begin
      o.busy = d1_busy; o.done = d1_done; o.rd_en = d1_rd_en; o.clr = d1_clr; o.last = d1_last;
      o.k = d1_k; o.tr = {1'b0, d1_tr}; o.tc = d1_tc; o.a = d1_a; o.b = d1_b;
    end else begin
      o.busy = d2_busy; o.done = d2_done; o.rd_en = d2_rd_en; o.clr = d2_clr; o.last = d2_last;
      o.k = d2_k; o.tr = d2_tr; o.tc = d2_tc; o.a = d2_a; o.b = d2_b;
    end
    return o;
  endfunction

  task automatic check_out(input string tag, input int sel, input out_t want);
    out_t got;
    got = get_out(sel);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input int sel, input logic st, input logic sl);
    if (sel == 1) begin start1 = st; stall1 = sl; end
    else          begin start2 = st; stall2 = sl; end
  endtask

  task automatic push_vec(input logic st, input logic sl, input out_t e);
    vec_t v;
    v.start = st; v.stall = sl; v.exp = e;
    vec_q.push_back(v);
  endtask

  // Builds the per-cycle vector table of one operation from the tile loop nest.
  // s0/s1: beats preceded by slen stall cycles; stop_beat>=0 truncates the run.
  task automatic build_run(input int ta, input int tb, input int kd, input int s0,
                           input int s1, input int slen, input int stop_beat,
                           input logic hold, input int ba, input int bb,
                           input logic dstall);
    int beat;
    beat = 0;
    push_vec(1'b1, 1'b0, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int r = 0; r < ta; r++)
      for (int c = 0; c < tb; c++)
        for (int k = 0; k < kd; k++) begin
          if (stop_beat >= 0 && beat >= stop_beat) return;
          if (beat == s0 || beat == s1)
            for (int s = 0; s < slen; s++)
              push_vec(hold, 1'b1, mk_out(1, 0, 0, 0, 0, k, r, c, r*kd + k + ba, c*kd + k + bb));
          push_vec(hold, 1'b0, mk_out(1, 0, 1, k == 0, k == kd - 1, k, r, c,
                                      r*kd + k + ba, c*kd + k + bb));
          beat++;
        end
    for (int d = 0; d < DRAIN; d++)
      push_vec(hold, dstall && (d == 2), mk_out(1, 0, 0, 0, 0, 0, 0, 0, ba, bb));
    push_vec(hold, 1'b0, mk_out(0, 1, 0, 0, 0, 0, 0, 0, ba, bb));
  endtask

  task automatic push_idle(input int ba, input int bb);
    push_vec(1'b0, 1'b0, mk_out(0, 0, 0, 0, 0, 0, 0, 0, ba, bb));
  endtask

  // Applies the vector table one cycle per record; outputs sampled on negedge.
  task automatic apply(input string tag, input int sel);
    for (int i = 0; i < vec_q.size(); i++) begin
      set_in(sel, vec_q[i].start, vec_q[i].stall);
`ifdef TILED_ADDR_BASE_EN
      if (i == 1) begin base2_a = 4'd9; base2_b = 4'd6; end
`endif
      @(negedge clk);
      check_out($sformatf("%s[%0d]", tag, i), sel, vec_q[i].exp);
      @(posedge clk); #1;
    end
    set_in(sel, 1'b0, 1'b0);
    vec_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic seen;

    // reset state
    @(negedge clk);
    check_out("reset_d1", 1, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_out("reset_d2", 2, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_out("post_reset_d1", 1, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;

    // plain run: 32 beats, 7 drain, done
    build_run(2, 2, 8, -1, -1, 0, -1, 1'b0, 0, 0, 1'b0);
    push_idle(0, 0);
    apply("nostall", 1);

    // stalls before beats 3 and 20, plus a stall during drain
    build_run(2, 2, 8, 3, 20, 2, -1, 1'b0, 0, 0, 1'b1);
    push_idle(0, 0);
    apply("stall", 1);

    // start held high throughout: no restart until back in IDLE
    build_run(2, 2, 8, -1, -1, 0, -1, 1'b1, 0, 0, 1'b0);
    build_run(2, 2, 8, -1, -1, 0, -1, 1'b0, 0, 0, 1'b0);
    push_idle(0, 0);
    apply("start_held", 1);

    // reset on beat 12
    build_run(2, 2, 8, -1, -1, 0, 12, 1'b0, 0, 0, 1'b0);
    apply("abort_pre", 1);
    @(negedge clk);
    check_out("beat12", 1, mk_out(1, 0, 1, 0, 0, 4, 0, 1, 4, 12));
    #1 rst = 1'b1;
    #1 check_out("abort_zero", 1, mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (d1_done || d1_busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got=%0b want=0", seen);
    end
    @(posedge clk); #1;
    build_run(2, 2, 8, -1, -1, 0, -1, 1'b0, 0, 0, 1'b0);
    push_idle(0, 0);
    apply("after_abort", 1);

    // rectangular instance: 3 row tiles x 2 col tiles x 5 beats
    build_run(3, 2, 5, -1, -1, 0, -1, 1'b0, BA2, BB2, 1'b0);
    push_idle(BA2, BB2);
    apply("mr12", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
